rv_mem_arbiter: RTL and testbench
=================================

Name: rv_mem_arbiter

Overview:
Shares the single 32-bit RV memory port (SDRAM plus the 7x_xxxx BSRAM window) between three requesters:
- m0: firmware flash loader
- m1: PicoRV32 softcore
- m2: savestate/DMA engine

It sits between iosys-side masters and the SDRAM controller's rv_* port. It arbitrates, latches the winning request, sequences the downstream valid/ready handshake, routes read data back, and recovers from a hung downstream access with a timeout.

Parameters:
- ADDR_W, 23, byte address width of the rv port (8MB).
- TIMEOUT, 4095, max cycles a granted access may wait for rv_ready; 0 disables the timeout.
- ERR_RDATA, 32'hDEAD_BEEF, read data returned on a timed-out access.

Ports:
- clk  in  1  system clock (SNES mclk domain)
- reset  in  1  asynchronous, active-high reset
- mN_valid  in  1  request from master N (N=0,1,2); held high until mN_ready
- mN_addr  in  ADDR_W  byte address
- mN_wdata  in  32  write data
- mN_wstrb  in  4  byte strobes; 0 = read
- mN_ready  out  1  one-cycle completion pulse to master N
- mN_rdata  out  32  read data, valid while mN_ready=1
- rv_valid  out  1  downstream request, held until rv_ready
- rv_ready  in  1  downstream one-cycle completion pulse
- rv_addr  out  ADDR_W  latched address
- rv_wdata  out  32  latched write data
- rv_wstrb  out  4  latched strobes
- rv_rdata  in  32  downstream read data, valid with rv_ready
- owner  out  2  current grant: 0/1/2, 3 = none
- timeout_err  out  1  one-cycle pulse on a timed-out access
- err_cnt  out  8  count of timeouts, saturating at 255

Behaviour:
- Reset (async, any state): state=IDLE, owner=3, rv_valid=0, all mN_ready=0, mN_rdata=0, rv_addr/wdata/wstrb=0, timeout_err=0, err_cnt=0, rr_last=2. A transaction in flight at reset is abandoned; no ready pulse is issued.
- State IDLE:
  - Sample mN_valid each cycle.
  - Winner selection:
    - If m0_valid, m0 wins (absolute priority).
    - Else if m1_valid and m2_valid, round-robin: winner is the one not equal to rr_last.
    - Else the single requester wins.
  - On a winner, at the clock edge: latch its addr/wdata/wstrb into rv_*, set owner, rv_valid=1, clear the timeout counter, go to BUSY.
  - Latency: request seen in cycle T gives rv_valid=1 in cycle T+1.
- State BUSY:
  - rv_valid stays 1; rv_* stay frozen; master inputs are ignored.
  - On rv_ready=1: register mN_rdata=rv_rdata (writes too) and mN_ready=1 for the owner only, in cycle T+1 after rv_ready.
  - In that same edge: rv_valid=0, owner=3; if the owner was 1 or 2, rr_last=owner (m0 grants do not update rr_last); go to GAP.
- State GAP:
  - Exactly one cycle. mN_ready=0 again; no arbitration.
  - This lets the master drop valid so the same request is not re-granted. Then go to IDLE.
  - Minimum spacing between two downstream requests is therefore 3 cycles after rv_ready.
- Timeout:
  - The counter increments every BUSY cycle.
  - If it reaches TIMEOUT with rv_ready=0: rv_valid=0, owner gets mN_ready=1 with mN_rdata=ERR_RDATA, timeout_err=1 for one cycle, err_cnt increments if below 255, go to GAP.
  - If rv_ready=1 in the same cycle the count reaches TIMEOUT, this is a normal completion: no error, real rdata returned.
  - A late rv_ready arriving in GAP or IDLE after a timeout is ignored.
- Master protocol violations:
  - If the owner drops mN_valid during BUSY, the access still completes downstream and the ready pulse is still issued; the master is expected to ignore it.
  - A valid that stays high after its ready is treated as a new request after GAP.
- mN_ready is never asserted for a non-owner; at most one mN_ready is high in any cycle.
- All outputs are registered; no combinational path from any input to rv_* or mN_*.

Test Plan:
1. Single read: m1_valid=1, addr=0x000100, wstrb=0 → cycle+1: rv_valid=1, rv_addr=0x000100, owner=1. Drive rv_ready with rdata=0x12345678 two cycles later → m1_ready pulse next cycle with m1_rdata=0x12345678; owner=3; GAP then IDLE.
2. Priority: m0, m1, m2 all valid, each completing after 2 cycles → grant order m0, m0 (m0 re-asserts), then once m0 idles, m1, m2, m1, m2 (round-robin alternation); m0 grants leave rr_last unchanged.
3. Write pass-through: m2 writes addr=0x700004, wdata=0xCAFEF00D, wstrb=4'b0100 → rv_wdata/rv_wstrb match and stay stable through 10 stalled cycles until rv_ready; m2_ready pulses once.
4. Timeout: TIMEOUT=8, rv_ready never comes → after 8 BUSY cycles rv_valid=0, m1_ready=1 with m1_rdata=0xDEADBEEF, timeout_err=1, err_cnt=1. Repeat 300 times → err_cnt saturates at 255. Also rv_ready exactly at count 8 → no error.
5. Reset mid-transaction: assert reset while BUSY → rv_valid and owner=3 drop immediately (asynchronous); no mN_ready after release. Post-reset m1 request is granted normally.

Source files
------------

// File: rtl/rv_mem_arbiter.sv
// Three-master arbiter for the shared 32-bit RV memory port: m0 has absolute
// priority, m1/m2 alternate; one latched access in flight, with a hang timeout.
module rv_mem_arbiter #(
  parameter int unsigned ADDR_W    = 23,
  parameter int unsigned TIMEOUT   = 4095,
  parameter logic [31:0] ERR_RDATA = 32'hDEAD_BEEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_valid,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [31:0]       m0_wdata,
  input  logic [3:0]        m0_wstrb,
  output logic              m0_ready,
  output logic [31:0]       m0_rdata,
  input  logic              m1_valid,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [31:0]       m1_wdata,
  input  logic [3:0]        m1_wstrb,
  output logic              m1_ready,
  output logic [31:0]       m1_rdata,
  input  logic              m2_valid,
  input  logic [ADDR_W-1:0] m2_addr,
  input  logic [31:0]       m2_wdata,
  input  logic [3:0]        m2_wstrb,
  output logic              m2_ready,
  output logic [31:0]       m2_rdata,
  output logic              rv_valid,
  input  logic              rv_ready,
  output logic [ADDR_W-1:0] rv_addr,
  output logic [31:0]       rv_wdata,
  output logic [3:0]        rv_wstrb,
  input  logic [31:0]       rv_rdata,
  output logic [1:0]        owner,
  output logic              timeout_err,
  output logic [7:0]        err_cnt
);

  localparam int unsigned   CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);
  localparam bit            TO_EN  = (TIMEOUT != 0);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_GAP
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic [1:0]          r_owner;
  logic [1:0]          r_rr_last;
  logic                r_rv_valid;
  logic [ADDR_W-1:0]   r_rv_addr;
  logic [31:0]         r_rv_wdata;
  logic [3:0]          r_rv_wstrb;
  logic [2:0]          r_ready;
  logic [31:0]         r_m0_rdata;
  logic [31:0]         r_m1_rdata;
  logic [31:0]         r_m2_rdata;
  logic                r_terr;
  logic [7:0]          r_err_cnt;

  logic                w_grant_en;
  logic [1:0]          w_grant;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [31:0]         w_sel_wdata;
  logic [3:0]          w_sel_wstrb;
  logic                w_done;
  logic                w_to;
  logic [2:0]          w_owner_oh;
  logic [31:0]         w_ret_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_en  = 1'b0;
    w_grant     = 2'd0;
    w_done      = 1'b0;
    w_to        = 1'b0;
    w_cnt_nxt   = r_cnt + CNT_W'(1);
    unique case (r_state)
      ST_IDLE: begin
        // rr_last only ever holds 1 or 2, so the contested pick is "the other one"
        if (m0_valid) begin
          w_grant_en = 1'b1;
          w_grant    = 2'd0;
        end else if (m1_valid && m2_valid) begin
          w_grant_en = 1'b1;
          w_grant    = (r_rr_last == 2'd1) ? 2'd2 : 2'd1;
        end else if (m1_valid) begin
          w_grant_en = 1'b1;
          w_grant    = 2'd1;
        end else if (m2_valid) begin
          w_grant_en = 1'b1;
          w_grant    = 2'd2;
        end
        if (w_grant_en) w_state_nxt = ST_BUSY;
      end
      ST_BUSY: begin
        if (rv_ready)                             w_done = 1'b1;
        else if (TO_EN && (w_cnt_nxt == TO_VAL))  w_to   = 1'b1;
        if (w_done || w_to) w_state_nxt = ST_GAP;
      end
      ST_GAP:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    w_sel_wstrb = '0;
    unique case (w_grant)
      2'd0: begin
        w_sel_addr  = m0_addr;
        w_sel_wdata = m0_wdata;
        w_sel_wstrb = m0_wstrb;
      end
      2'd1: begin
        w_sel_addr  = m1_addr;
        w_sel_wdata = m1_wdata;
        w_sel_wstrb = m1_wstrb;
      end
      2'd2: begin
        w_sel_addr  = m2_addr;
        w_sel_wdata = m2_wdata;
        w_sel_wstrb = m2_wstrb;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_owner_oh = '0;
    unique case (r_owner)
      2'd0:    w_owner_oh = 3'b001;
      2'd1:    w_owner_oh = 3'b010;
      2'd2:    w_owner_oh = 3'b100;
      default: w_owner_oh = '0;
    endcase
    w_ret_data = w_done ? rv_rdata : ERR_RDATA;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt      <= '0;
      r_owner    <= 2'd3;
      r_rr_last  <= 2'd2;
      r_rv_valid <= 1'b0;
      r_rv_addr  <= '0;
      r_rv_wdata <= '0;
      r_rv_wstrb <= '0;
      r_ready    <= '0;
      r_m0_rdata <= '0;
      r_m1_rdata <= '0;
      r_m2_rdata <= '0;
      r_terr     <= 1'b0;
      r_err_cnt  <= '0;
    end else begin
      r_ready <= '0;
      r_terr  <= 1'b0;
      if (w_grant_en) begin
        r_rv_addr  <= w_sel_addr;
        r_rv_wdata <= w_sel_wdata;
        r_rv_wstrb <= w_sel_wstrb;
        r_owner    <= w_grant;
        r_rv_valid <= 1'b1;
        r_cnt      <= '0;
      end else if (r_state == ST_BUSY) begin
        r_cnt <= w_cnt_nxt;
        if (w_done || w_to) begin
          r_rv_valid <= 1'b0;
          r_owner    <= 2'd3;
          r_ready    <= w_owner_oh;
          if (w_owner_oh[0]) r_m0_rdata <= w_ret_data;
          if (w_owner_oh[1]) r_m1_rdata <= w_ret_data;
          if (w_owner_oh[2]) r_m2_rdata <= w_ret_data;
          if (r_owner != 2'd0) r_rr_last <= r_owner;
          if (w_to) begin
            r_terr <= 1'b1;
            if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
          end
        end
      end
    end
  end

  assign rv_valid    = r_rv_valid;
  assign rv_addr     = r_rv_addr;
  assign rv_wdata    = r_rv_wdata;
  assign rv_wstrb    = r_rv_wstrb;
  assign owner       = r_owner;
  assign m0_ready    = r_ready[0];
  assign m1_ready    = r_ready[1];
  assign m2_ready    = r_ready[2];
  assign m0_rdata    = r_m0_rdata;
  assign m1_rdata    = r_m1_rdata;
  assign m2_rdata    = r_m2_rdata;
  assign timeout_err = r_terr;
  assign err_cnt     = r_err_cnt;

endmodule

// File: tb/tb_rv_mem_arbiter.sv
// Randomised and directed bench for rv_mem_arbiter against a transaction-level
// reference model of the arbitration, completion and timeout rules.
module tb_rv_mem_arbiter;

  localparam int unsigned AW  = 23;
  localparam int          TO  = 12;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;

  logic              clk = 1'b0;
  logic              reset;
  logic [2:0]        mv;
  logic [AW-1:0]     ma  [3];
  logic [31:0]       mw  [3];
  logic [3:0]        ms  [3];
  logic [2:0]        mr;
  logic [31:0]       mrd [3];
  logic              rv_valid, rv_ready;
  logic [AW-1:0]     rv_addr;
  logic [31:0]       rv_wdata, rv_rdata;
  logic [3:0]        rv_wstrb;
  logic [1:0]        owner;
  logic              timeout_err;
  logic [7:0]        err_cnt;

  rv_mem_arbiter #(.ADDR_W(AW), .TIMEOUT(TO), .ERR_RDATA(ERR)) dut (
    .clk(clk), .reset(reset),
    .m0_valid(mv[0]), .m0_addr(ma[0]), .m0_wdata(mw[0]), .m0_wstrb(ms[0]),
    .m0_ready(mr[0]), .m0_rdata(mrd[0]),
    .m1_valid(mv[1]), .m1_addr(ma[1]), .m1_wdata(mw[1]), .m1_wstrb(ms[1]),
    .m1_ready(mr[1]), .m1_rdata(mrd[1]),
    .m2_valid(mv[2]), .m2_addr(ma[2]), .m2_wdata(mw[2]), .m2_wstrb(ms[2]),
    .m2_ready(mr[2]), .m2_rdata(mrd[2]),
    .rv_valid(rv_valid), .rv_ready(rv_ready), .rv_addr(rv_addr),
    .rv_wdata(rv_wdata), .rv_wstrb(rv_wstrb), .rv_rdata(rv_rdata),
    .owner(owner), .timeout_err(timeout_err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: phase 0 = free, 1 = access outstanding, 2 = turnaround
  int            ph, own, age, rr, errc;
  bit            e_rvv, e_terr;
  bit [2:0]      e_rdy;
  logic [AW-1:0] e_addr;
  logic [31:0]   e_wdata;
  logic [3:0]    e_wstrb;
  logic [31:0]   e_rd [3];

  // Stimulus control
  bit            rnd_en = 0;
  int            reqs_left [3];
  int            force_tgt = -1;
  int            tgt = 1;
  bit            rd_fix = 0;
  logic [31:0]   rd_val = '0;
  bit            rec = 0;
  int            grants [$];
  int            prev_owner = 3;
  int            pulse_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    ph = 0; own = 3; age = 0; rr = 2; errc = 0;
    e_rvv = 0; e_terr = 0; e_rdy = '0;
    e_addr = '0; e_wdata = '0; e_wstrb = '0;
    for (int i = 0; i < 3; i++) e_rd[i] = '0;
  endtask

  task automatic model_tick();
    int w;
    e_rdy  = '0;
    e_terr = 0;
    if (reset) begin
      model_reset();
      return;
    end
    case (ph)
      0: begin
        w = -1;
        if (mv[0])               w = 0;
        else if (mv[1] && mv[2]) w = (rr == 1) ? 2 : 1;
        else if (mv[1])          w = 1;
        else if (mv[2])          w = 2;
        if (w >= 0) begin
          own = w; e_addr = ma[w]; e_wdata = mw[w]; e_wstrb = ms[w];
          e_rvv = 1; age = 0; ph = 1;
        end
      end
      1: begin
        age++;
        if (rv_ready || age == TO) begin
          e_rdy[own] = 1'b1;
          e_rd[own]  = rv_ready ? rv_rdata : ERR;
          if (!rv_ready) begin
            e_terr = 1;
            if (errc < 255) errc++;
          end
          if (own != 0) rr = own;
          own = 3; e_rvv = 0; ph = 2;
        end
      end
      default: ph = 0;
    endcase
  endtask

  task automatic compare_all();
    chk("rv_valid", 32'(rv_valid), 32'(e_rvv));
    chk("owner", 32'(owner), 32'(own));
    chk("rv_addr", 32'(rv_addr), 32'(e_addr));
    chk("rv_wdata", rv_wdata, e_wdata);
    chk("rv_wstrb", 32'(rv_wstrb), 32'(e_wstrb));
    for (int i = 0; i < 3; i++) begin
      chk("m_ready", 32'(mr[i]), 32'(e_rdy[i]));
      if (e_rdy[i]) chk("m_rdata", mrd[i], e_rd[i]);
    end
    chk("timeout_err", 32'(timeout_err), 32'(e_terr));
    chk("err_cnt", 32'(err_cnt), 32'(errc));
  endtask

  task automatic new_req(input int i);
    mv[i] = 1'b1;
    ma[i] = AW'($urandom);
    mw[i] = $urandom;
    ms[i] = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
  endtask

  task automatic drive();
    for (int i = 0; i < 3; i++) begin
      if (rnd_en) begin
        if (!mv[i]) begin
          if ($urandom_range(0, 99) < 30) new_req(i);
        end else if (e_rdy[i]) begin
          if ($urandom_range(0, 3) == 0) new_req(i);
          else mv[i] = 1'b0;
        end else if ($urandom_range(0, 49) == 0) begin
          mv[i] = 1'b0;
        end
      end else if (e_rdy[i]) begin
        if (reqs_left[i] > 0) reqs_left[i]--;
        if (reqs_left[i] > 0) new_req(i);
        else mv[i] = 1'b0;
      end
    end
    if (ph == 1 && age == 0)
      tgt = (force_tgt >= 0) ? force_tgt : $urandom_range(1, TO + 3);
    if (ph == 1) rv_ready = (age + 1 == tgt);
    else         rv_ready = ($urandom_range(0, 7) == 0);
    rv_rdata = rd_fix ? rd_val : $urandom;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_tick();
    @(negedge clk);
    compare_all();
    if (rec && owner != 2'd3 && prev_owner == 3) grants.push_back(int'(owner));
    prev_owner = int'(owner);
    if (mr[2]) pulse_cnt++;
    drive();
  endtask

  task automatic run_until_done(input string tag, input int budget);
    bit done;
    done = 0;
    for (int c = 0; c < budget && !done; c++) begin
      cyc();
      done = (reqs_left[0] == 0 && reqs_left[1] == 0 && reqs_left[2] == 0 &&
              mv == 3'b000 && ph == 0);
    end
    chk({tag, "_done"}, 32'(done), 32'(1));
  endtask

  task automatic start_req(input int i, input logic [AW-1:0] a, input logic [31:0] d,
                           input logic [3:0] s, input int n);
    mv[i] = 1'b1; ma[i] = a; mw[i] = d; ms[i] = s; reqs_left[i] = n;
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    model_reset();
    for (int c = 0; c < cycles; c++) cyc();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; mv = '0; rv_ready = 1'b0; rv_rdata = '0;
    for (int i = 0; i < 3; i++) begin
      ma[i] = '0; mw[i] = '0; ms[i] = '0; reqs_left[i] = 0;
    end
    model_reset();
    do_reset(3);
    for (int i = 0; i < 3; i++) chk("reset_rdata", mrd[i], 32'h0);
    cyc();

    // single read by m1
    force_tgt = 2; rd_fix = 1; rd_val = 32'h1234_5678;
    start_req(1, 23'h000100, 32'h0, 4'h0, 1);
    run_until_done("single_read", 40);
    chk("single_rdata", mrd[1], 32'h1234_5678);
    rd_fix = 0;

    // priority and round-robin from a fresh reset (rr_last = 2)
    do_reset(2);
    rec = 1; grants.delete(); prev_owner = 3;
    start_req(0, AW'($urandom), $urandom, 4'h0, 2);
    start_req(1, AW'($urandom), $urandom, 4'h0, 2);
    start_req(2, AW'($urandom), $urandom, 4'hF, 2);
    run_until_done("priority", 100);
    rec = 0;
    begin
      int exp_seq [6];
      exp_seq = '{0, 0, 1, 2, 1, 2};
      chk("grant_count", 32'(grants.size()), 32'(6));
      for (int k = 0; k < 6; k++)
        chk("grant_seq", 32'((k < grants.size()) ? grants[k] : 9), 32'(exp_seq[k]));
    end

    // write held through a 10-cycle stall
    force_tgt = 11; pulse_cnt = 0;
    start_req(2, 23'h700004, 32'hCAFE_F00D, 4'b0100, 1);
    run_until_done("write_stall", 40);
    chk("m2_pulses", 32'(pulse_cnt), 32'(1));

    // timeouts until the error counter saturates
    force_tgt = TO + 5;
    start_req(1, AW'($urandom), $urandom, 4'h0, 300);
    run_until_done("timeouts", 300 * (TO + 3) + 50);
    chk("err_sat", 32'(err_cnt), 32'(255));

    // ready arriving on the very cycle the count reaches the limit
    force_tgt = TO;
    start_req(1, AW'($urandom), $urandom, 4'h0, 1);
    run_until_done("edge_ready", 40);

    // asynchronous reset while an access is outstanding
    force_tgt = TO + 5;
    start_req(1, AW'($urandom), $urandom, 4'h0, 1);
    for (int c = 0; c < 4; c++) cyc();
    #2;
    reset = 1'b1;
    model_reset();
    mv = '0; reqs_left[1] = 0;
    #1;
    chk("async_rv_valid", 32'(rv_valid), 32'(0));
    chk("async_owner", 32'(owner), 32'(3));
    for (int c = 0; c < 2; c++) cyc();
    reset = 1'b0;
    for (int c = 0; c < 4; c++) cyc();
    force_tgt = 2;
    start_req(1, AW'($urandom), $urandom, 4'h0, 1);
    run_until_done("post_reset", 40);

    // randomised traffic
    force_tgt = -1; rnd_en = 1;
    for (int c = 0; c < 4000; c++) cyc();
    rnd_en = 0; mv = '0;
    for (int c = 0; c < TO + 4; c++) cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
